// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings (also used by the main decoder),
// opcode legality check, loader error codes and loader state encoding.
package isa_pkg;

    localparam logic [5:0] OP_ADD     = 6'b000000;  // add/sub
    localparam logic [5:0] OP_ADDI    = 6'b010000;
    localparam logic [5:0] OP_FP      = 6'b000100;  // scalar fp
    localparam logic [5:0] OP_VFP     = 6'b001100;  // vector fp
    localparam logic [5:0] OP_SW      = 6'b010001;
    localparam logic [5:0] OP_LW      = 6'b010010;
    localparam logic [5:0] OP_SW_FP   = 6'b010101;
    localparam logic [5:0] OP_LW_FP   = 6'b010110;
    localparam logic [5:0] OP_VST     = 6'b011101;
    localparam logic [5:0] OP_VLD     = 6'b011110;
    localparam logic [5:0] OP_BEQ     = 6'b100000;
    localparam logic [5:0] OP_BLT     = 6'b100001;
    localparam logic [5:0] OP_J       = 6'b100010;
    localparam logic [5:0] OP_VSET_FP = 6'b111111;
    localparam logic [5:0] OP_START   = 6'b110010;  // program framing: begin
    localparam logic [5:0] OP_CLOSE   = 6'b110001;  // program framing: end

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_START    = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } loader_state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_FP, OP_VFP, OP_SW, OP_LW, OP_SW_FP, OP_LW_FP,
            OP_VST, OP_VLD, OP_BEQ, OP_BLT, OP_J, OP_VSET_FP, OP_START,
            OP_CLOSE: is_legal_op = 1'b1;
            default:  is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// master: host/memory side, slave: the loader.
interface instr_loader_if #(
    parameter int IMEM_AW = 10
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words. The completed word
// and word_valid are presented combinationally in the cycle the 4th byte is
// accepted, so the FSM acts on it at that same edge.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] pack_q, pack_d;

    // Byte counter / pack register update and word completion
    always_comb begin
        cnt_d      = cnt_q;
        pack_d     = pack_q;
        word_valid = byte_en && (cnt_q == 2'd3);
        word       = {byte_data, pack_q};
        if (clear) begin
            cnt_d  = 2'd0;
            pack_d = '0;
        end else if (byte_en) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    pack_d[7:0]   = byte_data;
                2'd1:    pack_d[15:8]  = byte_data;
                2'd2:    pack_d[23:16] = byte_data;
                default: pack_d        = '0;
            endcase
        end
    end

    // Assembler registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            pack_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
        end
    end
endmodule

// File: rtl/instr_loader.sv
// Program loader: frames a START..CLOSE image from the host byte stream,
// validates opcodes and writes the image into instruction memory.
//
// state | meaning
// IDLE  | waiting for a START word; other words dropped
// LOAD  | writing program words, CLOSE included
// DONE  | image complete, core may run; holds until clear
// ERR   | load aborted (see err_code); holds until clear
module instr_loader
    import isa_pkg::*;
#(
    parameter int IMEM_AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    instr_loader_if.slave        bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [IMEM_AW:0]     word_count
);
    localparam logic [IMEM_AW:0] CAPACITY = {1'b1, {IMEM_AW{1'b0}}};

    loader_state_t      state_q, state_d;
    err_code_t          err_code_q, err_code_d;
    logic [IMEM_AW:0]   word_count_q, word_count_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;

    logic        byte_en;
    logic        word_valid;
    logic [31:0] word;
    logic [5:0]  opcode;
    logic        op_legal;
    logic        op_start;
    logic        op_close;
    logic        mem_full;
    logic        load_word;
    logic        write_word;

    assign bus.in_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !clear;
    assign byte_en      = bus.in_valid && bus.in_ready;

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_en    (byte_en),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign opcode     = word[31:26];
    assign op_legal   = is_legal_op(opcode);
    assign op_start   = (opcode == OP_START);
    assign op_close   = (opcode == OP_CLOSE);
    assign mem_full   = (word_count_q == CAPACITY);
    assign load_word  = !clear && (state_q == ST_LOAD) && word_valid;
    assign write_word = load_word && op_legal && !op_start && !mem_full;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            err_code_q   <= ERR_NONE;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            word_count_q <= word_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    // Next state and error classification; rule order sets error priority
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        if (clear) begin
            state_d    = ST_IDLE;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (word_valid && op_start) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        if (!op_legal) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_ILLEGAL;
                        end else if (op_start) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_START;
                        end else if (mem_full) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_OVERFLOW;
                        end else if (op_close) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Memory write strobe, address/data capture and word counting
    always_comb begin
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        word_count_d = word_count_q;
        if (clear) begin
            word_count_d = '0;
        end else if ((state_q == ST_IDLE) && word_valid && op_start) begin
            word_count_d = '0;
        end else if (write_word) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[IMEM_AW-1:0];
            imem_wdata_d = word;
            word_count_d = word_count_q + 1'b1;
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign busy           = (state_q == ST_LOAD);
    assign done           = (state_q == ST_DONE);
    assign error          = (state_q == ST_ERR);
    assign err_code       = err_code_q;
    assign word_count     = word_count_q;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances (1024-word and 4-word memories) see
// the same byte stream; a byte-level reference model predicts both.
module tb_instr_loader;

    localparam logic [31:0] W_START = 32'hC800_0000;
    localparam logic [31:0] W_CLOSE = 32'hC400_0000;
    localparam int S_IDLE = 0, S_LOAD = 1, S_DONE = 2, S_ERR = 3;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        busy0, done0, error0, busy1, done1, error1;
    logic [1:0]  ec0, ec1;
    logic [10:0] wc0;
    logic [2:0]  wc1;

    instr_loader_if #(.IMEM_AW(10)) bus ();
    instr_loader_if #(.IMEM_AW(2))  bus_s ();

    instr_loader #(.IMEM_AW(10)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .busy(busy0), .done(done0), .error(error0),
        .err_code(ec0), .word_count(wc0)
    );

    instr_loader #(.IMEM_AW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_s),
        .busy(busy1), .done(done1), .error(error1),
        .err_code(ec1), .word_count(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cap    [2] = '{1024, 4};
    int          m_st   [2];
    int          m_nb   [2];
    int          m_wc   [2];
    int          m_ec   [2];
    logic [31:0] m_part [2];
    bit          m_we   [2];
    int          m_addr [2];
    logic [31:0] m_wd   [2];

    logic [63:0] log0[$];
    logic [63:0] log1[$];

    int legal_ops[16] = '{0, 16, 4, 12, 17, 18, 21, 22, 29, 30, 32, 33, 34, 63, 50, 49};

    function automatic bit op_is_legal(input int op);
        for (int k = 0; k < 16; k++)
            if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = S_IDLE; m_nb[i] = 0; m_wc[i] = 0; m_ec[i] = 0;
            m_part[i] = '0; m_we[i] = 1'b0; m_addr[i] = 0; m_wd[i] = '0;
        end
    endtask

    // Spec rules applied to one byte-cycle of one instance
    task automatic model_step(input int i, input bit v, input logic [7:0] d, input bit clr);
        logic [31:0] w;
        int op;
        m_we[i] = 1'b0;
        if (clr) begin
            m_st[i] = S_IDLE; m_nb[i] = 0; m_part[i] = '0; m_wc[i] = 0; m_ec[i] = 0;
        end else if (v && (m_st[i] == S_IDLE || m_st[i] == S_LOAD)) begin
            m_part[i] = m_part[i] | (32'(d) << (8 * m_nb[i]));
            m_nb[i]++;
            if (m_nb[i] == 4) begin
                w = m_part[i];
                m_part[i] = '0;
                m_nb[i] = 0;
                op = int'(w >> 26);
                if (m_st[i] == S_IDLE) begin
                    if (op == 50) begin m_st[i] = S_LOAD; m_wc[i] = 0; end
                end else if (!op_is_legal(op)) begin
                    m_st[i] = S_ERR; m_ec[i] = 1;
                end else if (op == 50) begin
                    m_st[i] = S_ERR; m_ec[i] = 3;
                end else if (m_wc[i] == cap[i]) begin
                    m_st[i] = S_ERR; m_ec[i] = 2;
                end else begin
                    m_we[i] = 1'b1;
                    m_addr[i] = m_wc[i] % cap[i];
                    m_wd[i] = w;
                    m_wc[i]++;
                    if (op == 49) m_st[i] = S_DONE;
                end
            end
        end
    endtask

    // Registered outputs of both instances against the model
    task automatic check_regs();
        chk("busy", 0, 64'(busy0), 64'(m_st[0] == S_LOAD));
        chk("done", 0, 64'(done0), 64'(m_st[0] == S_DONE));
        chk("error", 0, 64'(error0), 64'(m_st[0] == S_ERR));
        chk("err_code", 0, 64'(ec0), 64'(m_ec[0]));
        chk("word_count", 0, 64'(wc0), 64'(m_wc[0]));
        chk("imem_we", 0, 64'(bus.imem_we), 64'(m_we[0]));
        if (m_we[0]) begin
            chk("imem_addr", 0, 64'(bus.imem_addr), 64'(m_addr[0]));
            chk("imem_wdata", 0, 64'(bus.imem_wdata), 64'(m_wd[0]));
        end
        chk("busy", 1, 64'(busy1), 64'(m_st[1] == S_LOAD));
        chk("done", 1, 64'(done1), 64'(m_st[1] == S_DONE));
        chk("error", 1, 64'(error1), 64'(m_st[1] == S_ERR));
        chk("err_code", 1, 64'(ec1), 64'(m_ec[1]));
        chk("word_count", 1, 64'(wc1), 64'(m_wc[1]));
        chk("imem_we", 1, 64'(bus_s.imem_we), 64'(m_we[1]));
        if (m_we[1]) begin
            chk("imem_addr", 1, 64'(bus_s.imem_addr), 64'(m_addr[1]));
            chk("imem_wdata", 1, 64'(bus_s.imem_wdata), 64'(m_wd[1]));
        end
        if (bus.imem_we === 1'b1)   log0.push_back({32'(bus.imem_addr), bus.imem_wdata});
        if (bus_s.imem_we === 1'b1) log1.push_back({32'(bus_s.imem_addr), bus_s.imem_wdata});
    endtask

    // One clock: drive at negedge, check in_ready, step model, check registers
    task automatic cycle(input bit v, input logic [7:0] d, input bit clr);
        bit rdy0, rdy1;
        bus.in_valid = v;   bus.in_data = d;
        bus_s.in_valid = v; bus_s.in_data = d;
        clear = clr;
        #1;
        rdy0 = (m_st[0] == S_IDLE || m_st[0] == S_LOAD) && !clr;
        rdy1 = (m_st[1] == S_IDLE || m_st[1] == S_LOAD) && !clr;
        chk("in_ready", 0, 64'(bus.in_ready), 64'(rdy0));
        chk("in_ready", 1, 64'(bus_s.in_ready), 64'(rdy1));
        @(posedge clk);
        model_step(0, v, d, clr);
        model_step(1, v, d, clr);
        @(negedge clk);
        check_regs();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] t;
        t = w;
        for (int b = 0; b < 4; b++) begin
            if (gaps && ($urandom_range(3) == 0)) cycle(1'b0, 8'($urandom), 1'b0);
            cycle(1'b1, t[7:0], 1'b0);
            t = t >> 8;
        end
    endtask

    // Asynchronous reset with literal reset-value checks
    task automatic do_reset();
        bus.in_valid = 1'b0;   bus.in_data = 8'h00;
        bus_s.in_valid = 1'b0; bus_s.in_data = 8'h00;
        clear = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", 0, 64'(bus.in_ready), 64'd1);
        chk("rst_in_ready", 1, 64'(bus_s.in_ready), 64'd1);
        chk("rst_outs", 0, {busy0, done0, error0, ec0, wc0, bus.imem_we}, 64'd0);
        chk("rst_outs", 1, {busy1, done1, error1, ec1, wc1, bus_s.imem_we}, 64'd0);
        chk("rst_addr_data", 0, {bus.imem_addr, bus.imem_wdata}, 64'd0);
        chk("rst_addr_data", 1, {bus_s.imem_addr, bus_s.imem_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        r = int'($urandom_range(99));
        if (r < 12) return W_START;
        if (r < 27) return W_CLOSE;
        if (r < 85) return {6'(legal_ops[$urandom_range(13)]), 26'($urandom)};
        return $urandom;
    endfunction

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid = 1'b0;   bus.in_data = 8'h00;
        bus_s.in_valid = 1'b0; bus_s.in_data = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // START, addi, CLOSE
        log0.delete(); log1.delete();
        send_word(W_START, 1'b0);
        send_word(32'h4000_0001, 1'b0);
        send_word(W_CLOSE, 1'b0);
        chk("t1_nwrites", 0, 64'(log0.size()), 64'd2);
        if (log0.size() == 2) begin
            chk("t1_write0", 0, log0[0], {32'd0, 32'h4000_0001});
            chk("t1_write1", 0, log0[1], {32'd1, 32'hC400_0000});
        end
        chk("t1_word_count", 0, 64'(wc0), 64'd2);
        chk("t1_done", 0, 64'(done0), 64'd1);
        chk("t1_in_ready", 0, 64'(bus.in_ready), 64'd0);

        // non-START word in IDLE is dropped
        cycle(1'b0, 8'h00, 1'b1);
        log0.delete();
        send_word(32'h0000_0000, 1'b1);
        chk("t2_no_write", 0, 64'(log0.size()), 64'd0);
        chk("t2_idle", 0, 64'(busy0), 64'd0);
        send_word(W_START, 1'b1);
        chk("t2_busy", 0, 64'(busy0), 64'd1);

        // illegal opcode 000011
        send_word(32'h0C00_0000, 1'b0);
        chk("t3_error", 0, 64'(error0), 64'd1);
        chk("t3_err_code", 0, 64'(ec0), 64'd1);
        chk("t3_no_write", 0, 64'(log0.size()), 64'd0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t3_clr_wc", 0, 64'(wc0), 64'd0);
        chk("t3_clr_state", 0, 64'({busy0, done0, error0, ec0}), 64'd0);

        // overflow on the 4-word instance
        log1.delete();
        send_word(W_START, 1'b0);
        for (int k = 0; k < 5; k++) send_word(32'h4000_0010 + 32'(k), 1'b1);
        chk("t4_nwrites", 1, 64'(log1.size()), 64'd4);
        for (int k = 0; k < 4 && k < log1.size(); k++)
            chk("t4_addr", 1, 64'(log1[k][63:32]), 64'(k));
        chk("t4_err_code", 1, 64'(ec1), 64'd2);
        chk("t4_word_count", 1, 64'(wc1), 64'd4);
        chk("t4_big_busy", 0, 64'(busy0), 64'd1);

        // reset mid-word in LOAD
        cycle(1'b0, 8'h00, 1'b1);
        send_word(W_START, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        do_reset();
        log0.delete();
        send_word(W_START, 1'b0);
        send_word(W_CLOSE, 1'b0);
        chk("t5_nwrites", 0, 64'(log0.size()), 64'd1);
        if (log0.size() == 1) chk("t5_write0", 0, log0[0], {32'd0, 32'hC400_0000});
        chk("t5_done", 0, 64'(done0), 64'd1);

        // START inside LOAD
        cycle(1'b0, 8'h00, 1'b1);
        send_word(W_START, 1'b0);
        send_word(W_START, 1'b0);
        chk("t6_err_code", 0, 64'(ec0), 64'd3);

        // byte offered together with clear must be dropped
        cycle(1'b1, 8'h00, 1'b1);
        send_word(W_START, 1'b0);
        chk("t7_busy", 0, 64'(busy0), 64'd1);

        // randomized traffic
        for (int k = 0; k < 450; k++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 5)       cycle(1'($urandom), 8'($urandom), 1'b1);
            else if (r < 7)  do_reset();
            else if (r < 9)  cycle(1'b1, 8'($urandom), 1'b0);
            else             send_word(rand_word(), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
